program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Front-end stage feeding the CPU's code memory write port from the 16 user switches.
//   Debounces a LOAD and a RUN push-button and writes one switch word per LOAD press
//   into sequential code-memory addresses 0..63.
//   Holds the CPU in reset while loading and releases it on RUN.
//   The top level selects this block's write port over the CPU's own imem write whenever cpu_rst=1.
// PARAMETERS
//   ADDR_W        6    code memory address width
//   DATA_W        16   instruction / switch word width
//   DEPTH         64   number of code memory words (2**ADDR_W)
//   DEBOUNCE_CYC  4    consecutive stable cycles needed to accept a button level change
// PORTS
//   clk         in   1        clock, all state on rising edge
//   rst         in   1        synchronous active-high reset
//   switches    in   DATA_W   user word to be written
//   load_btn    in   1        raw (bouncy) LOAD button
//   run_btn     in   1        raw (bouncy) RUN button
//   im_write    out  1        code memory write enable, one-cycle pulse
//   im_waddr    out  ADDR_W   code memory write address
//   im_wdata    out  DATA_W   code memory write data
//   cpu_rst     out  1        reset to CPU; 1 = CPU held in reset
//   loading     out  1        1 while FSM is in LOAD
//   word_count  out  ADDR_W+1 words written since last (re)load, 0..DEPTH
//   full        out  1        word_count == DEPTH
// BEHAVIOUR
//   Reset values:
//     state=LOAD, ptr=0, word_count=0, full=0, im_write=0, im_waddr=0, im_wdata=0,
//     cpu_rst=1, loading=1, debounced levels=0, debounce counters=0.
//   Debounce (per button):
//     - Counter increments while raw != debounced level, and clears when they are equal.
//     - When the counter reaches DEBOUNCE_CYC, the level flips and the counter clears.
//     - A 0->1 flip of the debounced level yields a one-cycle press pulse.
//     - Raw high first sampled at edge k gives the pulse in cycle k+DEBOUNCE_CYC.
//     - Any glitch shorter than DEBOUNCE_CYC cycles produces no pulse.
//   FSM LOAD:
//     - load pulse and !full: on the next edge drive im_write=1 for exactly 1 cycle,
//       im_waddr=ptr, and im_wdata=switches sampled in the pulse cycle;
//       ptr++ and word_count++ on the same edge.
//     - load pulse and full: ignored; no write, counters unchanged.
//     - ptr saturates; it never wraps to 0 while in LOAD.
//     - run pulse with no load pulse in the same cycle: move to RUN; cpu_rst=0 and
//       loading=0 from the next edge. Running with word_count=0 is legal.
//     - load and run pulses in the same cycle: load is served, run is dropped.
//   FSM RUN:
//     - im_write held 0; run pulses ignored.
//     - load pulse: move to LOAD; on the next edge cpu_rst=1, loading=1, ptr=0,
//       word_count=0, full=0. No write for this press; the next press writes address 0.
//   Width and timing rules:
//     - word_count is ADDR_W+1 bits so that DEPTH is representable.
//     - full is registered alongside word_count.
//     - im_waddr and im_wdata hold their last values while im_write=0.
//   Reset mid-operation:
//     - rst wins over everything. A write pending from a pulse in the rst cycle is dropped;
//       im_write=0 in the cycle after rst.
//     - Code memory contents are not cleared.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined:
//     - Adds output port checksum (DATA_W).
//     - checksum = XOR of every word written since the last reset or reload.
//     - Updated on the same edge as im_write.
//     - Cleared to 0 on rst and on the RUN->LOAD transition.
//   LOADER_CHECKSUM_EN undefined:
//     - Port absent; no XOR register is synthesised.
//     - All other behaviour is identical.
// TESTING
//   1. rst; switches=16'hA5C3; load_btn high 6 cycles
//      -> exactly one im_write at waddr 0, wdata A5C3, 5 cycles after raw rise; word_count=1.
//   2. load_btn toggles 1,0,1,0,1,0 on consecutive cycles -> no im_write; word_count stays 0.
//   3. 65 clean LOAD presses with switches=press index
//      -> 64 writes, addresses 0..63, last wdata 16'h003F; full=1;
//         65th press produces no write; word_count=64.
//   4. 3 loads, then RUN press -> cpu_rst=0, loading=0 next edge.
//      Then LOAD press -> cpu_rst=1, word_count=0, no write.
//      Next LOAD press writes address 0.
//   5. LOAD and RUN raw rises on the same cycle in LOAD -> one write; state stays LOAD; cpu_rst=1.
//   6. rst asserted in the load-pulse cycle -> im_write=0 next cycle; word_count=0.
//   7. LOADER_CHECKSUM_EN: write 16'h00FF then 16'hFF00 -> checksum=16'hFFFF.
//      RUN then LOAD -> checksum=0.

Source files
------------

// File: rtl/program_loader_if.sv
// Bundle of the loader's user-facing inputs and code-memory / CPU-control outputs.
// The checksum signal exists only when LOADER_CHECKSUM_EN is defined.
interface program_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] switches;
  logic              load_btn;
  logic              run_btn;
  logic              im_write;
  logic [ADDR_W-1:0] im_waddr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_rst;
  logic              loading;
  logic [ADDR_W:0]   word_count;
  logic              full;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  modport master (
`ifdef LOADER_CHECKSUM_EN
    input  checksum,
`endif
    output switches, load_btn, run_btn,
    input  im_write, im_waddr, im_wdata, cpu_rst, loading, word_count, full
  );

  modport slave (
`ifdef LOADER_CHECKSUM_EN
    output checksum,
`endif
    input  switches, load_btn, run_btn,
    output im_write, im_waddr, im_wdata, cpu_rst, loading, word_count, full
  );
endinterface

// File: rtl/program_loader.sv
// Debounces LOAD/RUN buttons, writes one switch word per LOAD press into code memory
// and holds the CPU in reset while loading. LOADER_CHECKSUM_EN adds an XOR checksum.
//
// state   | meaning
// ST_LOAD | CPU held in reset, LOAD presses write sequential addresses
// ST_RUN  | CPU released, a LOAD press returns to ST_LOAD and rewinds
module program_loader #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 64,
  parameter int DEBOUNCE_CYC = 4
) (
  input logic             clk,
  input logic             rst,
  program_loader_if.slave bus
);
  localparam int                CNT_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  // Index 0 is LOAD, index 1 is RUN.
  logic [1:0]       raw;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0]       lvl_dly_q;
  logic [1:0]       press_q, press_d;
  logic             load_press, run_press;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              im_write_q, im_write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign raw        = {bus.run_btn, bus.load_btn};
  assign load_press = press_q[0];
  assign run_press  = press_q[1];

  // The level flips on the DEBOUNCE_CYC-th consecutive differing sample; the press
  // pulse is the registered rising edge of that level, one cycle later.
  always_comb begin
    lvl_d   = lvl_q;
    press_d = lvl_q & ~lvl_dly_q;
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = '0;
      if (raw[b] != lvl_q[b]) begin
        if (db_cnt_q[b] == CNT_LAST) begin
          lvl_d[b] = raw[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    full_d     = full_q;
    im_write_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_LOAD: begin
        if (load_press) begin
          if (!full_q) begin
            im_write_d = 1'b1;
            waddr_d    = ptr_q;
            wdata_d    = bus.switches;
            ptr_d      = (ptr_q == PTR_MAX) ? ptr_q : ptr_q + ADDR_W'(1);
            count_d    = count_q + (ADDR_W + 1)'(1);
            full_d     = (count_d == COUNT_MAX);
          end
        end else if (run_press) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_press) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q   <= '{default: '0};
      lvl_q      <= '0;
      lvl_dly_q  <= '0;
      press_q    <= '0;
      state_q    <= ST_LOAD;
      ptr_q      <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      im_write_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      lvl_q      <= lvl_d;
      lvl_dly_q  <= lvl_q;
      press_q    <= press_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      im_write_q <= im_write_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (im_write_d) begin
      cks_d = cks_q ^ wdata_d;
    end
    if (state_q == ST_RUN && load_press) begin
      cks_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign bus.checksum = cks_q;
`endif

  assign bus.im_write   = im_write_q;
  assign bus.im_waddr   = waddr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.cpu_rst    = (state_q == ST_LOAD);
  assign bus.loading    = (state_q == ST_LOAD);
  assign bus.word_count = count_q;
  assign bus.full       = full_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus random button
// sequences compared against a press-level model of the loader.
module tb_program_loader;
  logic clk;
  logic rst;

  program_loader_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  program_loader #(
    .ADDR_W(6), .DATA_W(16), .DEPTH(64), .DEBOUNCE_CYC(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Press-level model of the loader.
  int          m_count;
  bit          m_run;
  logic [15:0] m_cks;
  logic [15:0] m_last_waddr;
  logic [15:0] m_last_wdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_val({tag, " word_count"}, 32'(bus.word_count), 32'(m_count));
    check_val({tag, " full"}, 32'(bus.full), 32'(m_count == 64));
    check_val({tag, " cpu_rst"}, 32'(bus.cpu_rst), 32'(!m_run));
    check_val({tag, " loading"}, 32'(bus.loading), 32'(!m_run));
    check_val({tag, " waddr_hold"}, 32'(bus.im_waddr), 32'(m_last_waddr));
    check_val({tag, " wdata_hold"}, 32'(bus.im_wdata), 32'(m_last_wdata));
`ifdef LOADER_CHECKSUM_EN
    check_val({tag, " checksum"}, 32'(bus.checksum), 32'(m_cks));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.load_btn = 1'b0;
    bus.run_btn  = 1'b0;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    m_count      = 0;
    m_run        = 1'b0;
    m_cks        = '0;
    m_last_waddr = '0;
    m_last_wdata = '0;
    repeat (2) @(negedge clk);
  endtask

  // Raise the selected buttons for 'hold' samples, then release long enough for
  // the low level to settle. A press of 4+ samples writes 5 cycles after the rise.
  task automatic press(input bit ld, input bit rn, input int hold, input logic [15:0] sw);
    bit lp, rp, exp_wr, new_run;
    lp      = ld && (hold >= 4);
    rp      = rn && (hold >= 4);
    exp_wr  = lp && !m_run && (m_count < 64);
    new_run = m_run;
    if (!m_run && rp && !lp) new_run = 1'b1;
    if (m_run && lp) new_run = 1'b0;
    @(negedge clk);
    bus.switches = sw;
    bus.load_btn = ld;
    bus.run_btn  = rn;
    for (int i = 1; i <= hold + 6; i++) begin
      @(negedge clk);
      check_val("im_write", 32'(bus.im_write), 32'(exp_wr && (i == 6)));
      check_val("cpu_rst_timing", 32'(bus.cpu_rst), 32'((i >= 6) ? !new_run : !m_run));
      if (exp_wr && i == 6) begin
        check_val("im_waddr", 32'(bus.im_waddr), 32'(m_count));
        check_val("im_wdata", 32'(bus.im_wdata), 32'(sw));
      end
      if (i == hold) begin
        bus.load_btn = 1'b0;
        bus.run_btn  = 1'b0;
      end
    end
    if (exp_wr) begin
      m_last_waddr = 16'(m_count);
      m_last_wdata = sw;
      m_cks        = m_cks ^ sw;
      m_count++;
    end
    if (m_run && lp) begin
      m_count = 0;
      m_cks   = '0;
    end
    m_run = new_run;
  endtask

  initial begin
    rst          = 1'b1;
    bus.switches = '0;
    bus.load_btn = 1'b0;
    bus.run_btn  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst im_write", 32'(bus.im_write), 32'd0);
    check_val("rst im_waddr", 32'(bus.im_waddr), 32'd0);
    check_val("rst im_wdata", 32'(bus.im_wdata), 32'd0);
    check_val("rst cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check_val("rst loading", 32'(bus.loading), 32'd1);
    check_val("rst word_count", 32'(bus.word_count), 32'd0);
    check_val("rst full", 32'(bus.full), 32'd0);
    do_reset();

    // Single-cycle toggling never survives the debouncer.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.load_btn = (i % 2 == 0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("toggle im_write", 32'(bus.im_write), 32'd0);
    end
    check_status("toggle");

    press(1'b1, 1'b0, 6, 16'hA5C3);
    check_status("first_load");

    // Reset sampled on the edge that would have performed the write.
    @(negedge clk);
    bus.switches = 16'h1234;
    bus.load_btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_val("rstmid pre im_write", 32'(bus.im_write), 32'd0);
    end
    bus.load_btn = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rstmid im_write", 32'(bus.im_write), 32'd0);
    check_val("rstmid word_count", 32'(bus.word_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("rstmid after im_write", 32'(bus.im_write), 32'd0);
    end
    m_count = 0; m_run = 1'b0; m_cks = '0; m_last_waddr = '0; m_last_wdata = '0;
    check_status("rstmid");

    // Fill all 64 words; the 65th press must be ignored.
    for (int p = 0; p < 65; p++) press(1'b1, 1'b0, 5, 16'(p));
    check_status("fill");
    check_val("fill last wdata", 32'(bus.im_wdata), 32'h003F);
    check_val("fill last waddr", 32'(bus.im_waddr), 32'd63);

    do_reset();
    for (int p = 0; p < 3; p++) press(1'b1, 1'b0, 4, 16'(16'h0100 + p));
    press(1'b0, 1'b1, 5, 16'h0);
    check_status("run");
    press(1'b1, 1'b0, 5, 16'hBEEF);
    check_status("reload");
    press(1'b1, 1'b0, 5, 16'h7777);
    check_status("reload_write");

    press(1'b1, 1'b1, 6, 16'h5A5A);
    check_status("simul");

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    press(1'b1, 1'b0, 5, 16'h00FF);
    press(1'b1, 1'b0, 5, 16'hFF00);
    check_val("cks ffff", 32'(bus.checksum), 32'hFFFF);
    press(1'b0, 1'b1, 5, 16'h0);
    press(1'b1, 1'b0, 5, 16'h0);
    check_val("cks cleared", 32'(bus.checksum), 32'h0);
`endif

    do_reset();
    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op < 10)       press(1'b1, 1'b0, int'($urandom_range(4, 8)), 16'($urandom));
      else if (op < 12)  press(1'b1, 1'b0, int'($urandom_range(1, 3)), 16'($urandom));
      else if (op < 15)  press(1'b0, 1'b1, int'($urandom_range(4, 8)), 16'($urandom));
      else if (op < 17)  press(1'b0, 1'b1, int'($urandom_range(1, 3)), 16'($urandom));
      else if (op < 19)  press(1'b1, 1'b1, int'($urandom_range(4, 7)), 16'($urandom));
      else               do_reset();
      check_status("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
